// File: rtl/pipeline_hazard_controller.sv
// Run/halt sequencing, load-use stall, branch flush and EX forwarding
// control for a 5-stage MIPS pipeline, with saturating event counters.
module pipeline_hazard_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             running,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_drain;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;
  logic             w_load_use;
  logic             w_run;

  assign w_run = (r_state == S_RUN);
  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) ||
                       (id_uses_rt && (ex_rd == id_rt)));

  assign running     = w_run;
  assign stall_count = r_stall;
  assign flush_count = r_flush;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    unique case (r_state)
      S_RUN: begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (w_load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      S_DRAIN: begin
        // PC frozen; IF/ID keeps loading NOPs so the tail drains out
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        if (branch_taken) begin
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fwd_a = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs))
      fwd_a = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rt))
      fwd_b = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt))
      fwd_b = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_drain <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (branch_taken) begin
            if (r_flush != '1) r_flush <= r_flush + 1'b1;
          end else if (w_load_use) begin
            if (r_stall != '1) r_stall <= r_stall + 1'b1;
          end else if (halt_req) begin
            r_state <= S_DRAIN;
            r_drain <= DRAIN_INIT;
          end
        end
        S_DRAIN: begin
          if (r_drain == '0) r_state <= S_HALT;
          else r_drain <= r_drain - 1'b1;
        end
        S_HALT: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and random stimulus for pipeline_hazard_controller,
// checked every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

  localparam int DRAIN = 4;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, halt_req;
  logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write;
  logic          branch_taken;
  logic          pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          running;
  logic [CW-1:0] stall_count, flush_count;

  int n_total = 0;
  int n_bad   = 0;

  // model: 0 idle, 1 run, 2 drain, 3 halt
  int m_mode, m_left, m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .running(running), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fw(input logic [4:0] src);
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 1;
    return 0;
  endfunction

  task automatic idle_inputs();
    rst = 0; start = 0; halt_req = 0; branch_taken = 0;
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  // Called at a negedge with inputs set; checks, then advances one cycle.
  task automatic step();
    bit lu;
    int e_pc, e_ife, e_iff, e_idf, e_exf;
    #1;
    lu = ex_mem_read && ex_rd != 0 &&
         (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    e_pc = 0; e_ife = 0; e_iff = 0; e_idf = 0; e_exf = 0;
    if (m_mode == 1) begin
      if (branch_taken) begin
        e_pc = 1; e_ife = 1; e_iff = 1; e_idf = 1; e_exf = 1;
      end else if (lu) begin
        e_idf = 1;
      end else begin
        e_pc = 1; e_ife = 1;
      end
    end else if (m_mode == 2) begin
      e_ife = 1; e_iff = 1;
      e_idf = branch_taken; e_exf = branch_taken;
    end
    chk("pc_en", 32'(pc_en), e_pc);
    chk("ifid_en", 32'(ifid_en), e_ife);
    chk("ifid_flush", 32'(ifid_flush), e_iff);
    chk("idex_flush", 32'(idex_flush), e_idf);
    chk("exmem_flush", 32'(exmem_flush), e_exf);
    chk("fwd_a", 32'(fwd_a), fw(ex_rs));
    chk("fwd_b", 32'(fwd_b), fw(ex_rt));
    chk("running", 32'(running), (m_mode == 1) ? 1 : 0);
    chk("stall_count", 32'(stall_count), m_stall);
    chk("flush_count", 32'(flush_count), m_flush);
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (branch_taken) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      else if (lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      else if (halt_req) begin
        m_mode = 2; m_left = DRAIN - 1;
      end
    end else if (m_mode == 2) begin
      if (m_left == 0) m_mode = 3;
      else m_left--;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    step();
    // start, then run
    rst = 0; start = 1; step();
    start = 0; step();
    // load-use on rs
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; step();
    ex_mem_read = 0; step();
    // ex_rd = 0 never stalls
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; step();
    // load-use on rt, masked by branch
    ex_rd = 7; id_rt = 7; id_uses_rt = 1; branch_taken = 1; step();
    idle_inputs(); step();
    // forwarding priority
    mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
    ex_rs = 3; ex_rt = 3; step();
    mem_reg_write = 0; step();
    wb_rd = 0; step();
    idle_inputs();
    // halt with simultaneous stall, then drain
    halt_req = 1; ex_mem_read = 1; ex_rd = 2; id_rs = 2; step();
    ex_mem_read = 0; step();
    halt_req = 0;
    for (int i = 0; i < DRAIN + 2; i++) begin
      branch_taken = (i == 1); step();
    end
    start = 1; step();
    // reset mid-drain
    rst = 1; start = 0; step();
    rst = 0; start = 1; step();
    start = 0; halt_req = 1; step();
    halt_req = 0; step();
    rst = 1; step();
    rst = 0; step();
    // saturate stall counter
    start = 1; step(); start = 0;
    for (int i = 0; i < CMAX + 2; i++) begin
      ex_mem_read = 1; ex_rd = 9; id_rs = 9; step();
    end
    idle_inputs(); step();
    // random
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(99) < 2);
      start = ($urandom_range(99) < 20);
      halt_req = ($urandom_range(99) < 4);
      branch_taken = ($urandom_range(99) < 12);
      id_rs = 5'($urandom_range(3));
      id_rt = 5'($urandom_range(3));
      id_uses_rt = 1'($urandom);
      ex_rs = 5'($urandom_range(3));
      ex_rt = 5'($urandom_range(3));
      ex_rd = 5'($urandom_range(3));
      ex_mem_read = ($urandom_range(99) < 40);
      mem_rd = 5'($urandom_range(3));
      mem_reg_write = 1'($urandom);
      wb_rd = 5'($urandom_range(3));
      wb_reg_write = 1'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
